buffer_sequencer: RTL and testbench

Control-side partner of the 10-slot percent-indexed buffer. It drives the buffer's slot index (`percent`), write data and fill/drain select (`emptyBuffer`), and accepts samples from an upstream source one slot at a time. When all slots are filled, it drains them in order. Each drained byte is captured on the buffer's strobe and presented to a downstream consumer through a valid/ready handshake.

---
 rtl/buffer_sequencer.sv | 174 +++++++++++++++++
 tb/tb_buffer_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/buffer_sequencer.sv
// Fill/drain sequencer for a DEPTH-slot percent-indexed buffer: writes upstream samples slot by
// slot, then reads them back in order and hands each byte to a consumer via valid/ready.
module buffer_sequencer #(
  parameter int unsigned DEPTH   = 10,
  parameter int unsigned TIMEOUT = 7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] sampleIn,
  input  logic       sampleValid,
  output logic       sampleReady,
  output logic [3:0] percent,
  output logic       emptyBuffer,
  output logic [7:0] writeValue,
  input  logic [7:0] bufferData,
  input  logic       bufferStrobe,
  output logic [7:0] dataOut,
  output logic       dataValid,
  input  logic       dataReady,
  output logic       busy,
  output logic       full,
  output logic       done,
  output logic       error
);

  localparam int unsigned        TimerW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [3:0]         LastSlot  = 4'(DEPTH - 1);
  localparam logic [TimerW-1:0]  TimerLast = TimerW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFillWait,
    StFillWrite,
    StDrainWait,
    StDrainHold
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        percent_q, percent_d;
  logic              empty_q, empty_d;
  logic [7:0]        write_value_q, write_value_d;
  logic [7:0]        data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;
  logic              sample_ready_q, sample_ready_d;
  logic              busy_q, busy_d;
  logic              full_q, full_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [TimerW-1:0] timer_q, timer_d;

  always_comb begin
    state_d       = state_q;
    percent_d     = percent_q;
    empty_d       = empty_q;
    write_value_d = write_value_q;
    data_out_d    = data_out_q;
    data_valid_d  = data_valid_q;
    full_d        = full_q;
    done_d        = 1'b0;
    error_d       = error_q;
    timer_d       = timer_q;

    unique case (state_q)
      StIdle: begin
        percent_d = '0;
        empty_d   = 1'b0;
        if (start) begin
          error_d = 1'b0;
          state_d = StFillWait;
        end
      end
      StFillWait: begin
        if (sampleValid) begin
          write_value_d = sampleIn;
          state_d       = StFillWrite;
        end
      end
      StFillWrite: begin
        // The buffer commits write_value_q to slot percent_q at the edge closing this cycle.
        timer_d = '0;
        if (percent_q == LastSlot) begin
          full_d    = 1'b1;
          percent_d = '0;
          empty_d   = 1'b1;
          state_d   = StDrainWait;
        end else begin
          percent_d = percent_q + 4'd1;
          state_d   = StFillWait;
        end
      end
      StDrainWait: begin
        if (bufferStrobe) begin
          data_out_d   = bufferData;
          data_valid_d = 1'b1;
          timer_d      = '0;
          state_d      = StDrainHold;
        end else if (timer_q == TimerLast) begin
          error_d   = 1'b1;
          empty_d   = 1'b0;
          full_d    = 1'b0;
          percent_d = '0;
          timer_d   = '0;
          state_d   = StIdle;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StDrainHold: begin
        if (dataReady) begin
          data_valid_d = 1'b0;
          timer_d      = '0;
          if (percent_q == LastSlot) begin
            empty_d   = 1'b0;
            percent_d = '0;
            full_d    = 1'b0;
            done_d    = 1'b1;
            state_d   = StIdle;
          end else begin
            // Each step toggles percent[0], which is what re-arms the buffer's strobe.
            percent_d = percent_q + 4'd1;
            state_d   = StDrainWait;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    sample_ready_d = (state_d == StFillWait);
    busy_d         = (state_d != StIdle);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      percent_q      <= '0;
      empty_q        <= 1'b0;
      write_value_q  <= '0;
      data_out_q     <= '0;
      data_valid_q   <= 1'b0;
      sample_ready_q <= 1'b0;
      busy_q         <= 1'b0;
      full_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      timer_q        <= '0;
    end else begin
      state_q        <= state_d;
      percent_q      <= percent_d;
      empty_q        <= empty_d;
      write_value_q  <= write_value_d;
      data_out_q     <= data_out_d;
      data_valid_q   <= data_valid_d;
      sample_ready_q <= sample_ready_d;
      busy_q         <= busy_d;
      full_q         <= full_d;
      done_q         <= done_d;
      error_q        <= error_d;
      timer_q        <= timer_d;
    end
  end

  assign sampleReady = sample_ready_q;
  assign percent     = percent_q;
  assign emptyBuffer = empty_q;
  assign writeValue  = write_value_q;
  assign dataOut     = data_out_q;
  assign dataValid   = data_valid_q;
  assign busy        = busy_q;
  assign full        = full_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule

// File: tb/tb_buffer_sequencer.sv
// Directed bench for buffer_sequencer: a small percent-indexed buffer model on one side, a
// scripted source and consumer on the other, expected bytes taken from what the source sent.
module tb_buffer_sequencer;

  localparam int unsigned Depth   = 10;
  localparam int unsigned Timeout = 7;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] sampleIn;
  logic       sampleValid;
  logic       sampleReady;
  logic [3:0] percent;
  logic       emptyBuffer;
  logic [7:0] writeValue;
  logic [7:0] bufferData   = 8'h00;
  logic       bufferStrobe = 1'b0;
  logic [7:0] dataOut;
  logic       dataValid;
  logic       dataReady;
  logic       busy;
  logic       full;
  logic       done;
  logic       error;

  always #5 clock = ~clock;

  buffer_sequencer #(
    .DEPTH  (Depth),
    .TIMEOUT(Timeout)
  ) u_dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .sampleIn    (sampleIn),
    .sampleValid (sampleValid),
    .sampleReady (sampleReady),
    .percent     (percent),
    .emptyBuffer (emptyBuffer),
    .writeValue  (writeValue),
    .bufferData  (bufferData),
    .bufferStrobe(bufferStrobe),
    .dataOut     (dataOut),
    .dataValid   (dataValid),
    .dataReady   (dataReady),
    .busy        (busy),
    .full        (full),
    .done        (done),
    .error       (error)
  );

  logic [26:0] outs;
  assign outs = {sampleReady, percent, emptyBuffer, writeValue, dataOut, dataValid, busy, full,
                 done, error};

  // Buffer model: writes while filling; on drain, strobes one cycle after emptyBuffer rises
  // or percent[0] toggles. A selected slot's strobe can be suppressed.
  logic [7:0] mem [16];
  logic       prev_empty    = 1'b0;
  logic       prev_bit0     = 1'b0;
  logic       suppress_en   = 1'b0;
  logic [3:0] suppress_slot = 4'd0;

  always @(posedge clock) begin
    if (!emptyBuffer) mem[percent] <= writeValue;
    bufferStrobe <= 1'b0;
    if (emptyBuffer && (!prev_empty || (percent[0] != prev_bit0)) &&
        !(suppress_en && (percent == suppress_slot))) begin
      bufferStrobe <= 1'b1;
      bufferData   <= mem[percent];
    end
    prev_empty <= emptyBuffer;
    prev_bit0  <= percent[0];
  end

  // Edge-counting monitor for acceptances, done pulses and sampleReady right after an accept.
  int   cyc        = 0;
  int   acc_cnt    = 0;
  int   done_cnt   = 0;
  int   ready_viol = 0;
  int   acc_edge  [64];
  int   done_edge [64];
  logic prev_acc   = 1'b0;

  always @(posedge clock) begin
    cyc++;
    if (prev_acc && sampleReady) ready_viol++;
    prev_acc = sampleValid && sampleReady;
    if (sampleValid && sampleReady) begin
      acc_edge[acc_cnt % 64] = cyc;
      acc_cnt++;
    end
    if (done) begin
      done_edge[done_cnt % 64] = cyc;
      done_cnt++;
    end
  end

  int n_vec = 0;
  int n_err = 0;
  int gap_tab [10] = '{0, 3, 1, 6, 2, 0, 5, 4, 1, 2};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Start together with a stray sample: the sample must not be taken in IDLE.
  task automatic pulse_start();
    int acc0;
    acc0        = acc_cnt;
    start       = 1'b1;
    sampleValid = 1'b1;
    sampleIn    = 8'hEE;
    @(negedge clock);
    start       = 1'b0;
    sampleValid = 1'b0;
    check("start_sample_ignored", acc_cnt - acc0, 0);
    check("after_start", {busy, sampleReady, error, percent, emptyBuffer}, {4'b1100, 4'd0});
  endtask

  task automatic send_sample(input logic [7:0] d, input int gap);
    sampleValid = 1'b0;
    repeat (gap) @(negedge clock);
    sampleIn    = d;
    sampleValid = 1'b1;
    for (int t = 0; t < 40 && !sampleReady; t++) @(negedge clock);
    if (!sampleReady) check("fill_ready_timeout", sampleReady, 1);
    @(negedge clock);
    sampleValid = 1'b0;
  endtask

  task automatic fill(input logic [7:0] base, input bit gaps, input bit poke);
    for (int i = 0; i < Depth; i++) begin
      if (poke && i == 5) begin
        start = 1'b1;
        repeat (2) @(negedge clock);
        start = 1'b0;
        check("poke_fill", {busy, sampleReady, percent}, {2'b11, 4'd5});
      end
      send_sample(base + 8'(i), gaps ? gap_tab[i] : 0);
    end
  endtask

  task automatic drain(input logic [7:0] base, input int stall_slot, input bit poke,
                       input int stop_at);
    for (int k = 0; k < stop_at; k++) begin
      int t;
      t = 0;
      while (!dataValid && t < 30) begin
        @(negedge clock);
        t++;
      end
      check("drain_valid", dataValid, 1);
      check("drain_data", dataOut, base + 8'(k));
      check("drain_percent", percent, k);
      check("drain_full_empty", {full, emptyBuffer}, 2'b11);
      if (k == stall_slot) begin
        dataReady = 1'b0;
        repeat (5) begin
          @(negedge clock);
          check("hold", {dataValid, percent, dataOut}, {1'b1, 4'(k), base + 8'(k)});
        end
        dataReady = 1'b1;
      end
      if (poke && k == 6) start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
  endtask

  task automatic full_run(input logic [7:0] base, input bit gaps, input int stall_slot,
                          input bit poke, input bit timing);
    int acc0, done0, viol0;
    acc0  = acc_cnt;
    done0 = done_cnt;
    viol0 = ready_viol;
    pulse_start();
    fill(base, gaps, poke);
    drain(base, stall_slot, poke, Depth);
    check("run_end", {done, busy, full, emptyBuffer, percent, dataValid},
          {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0});
    @(negedge clock);
    check("done_one_cycle", {done, busy}, 2'b00);
    check("done_count", done_cnt - done0, 1);
    check("accept_count", acc_cnt - acc0, Depth);
    check("ready_in_fill_write", ready_viol - viol0, 0);
    if (timing) check("run_cycles", done_edge[done0 % 64] - acc_edge[acc0 % 64], 50);
  endtask

  initial begin
    int n;
    int done0;
    reset       = 1'b0;
    start       = 1'b0;
    sampleIn    = 8'h00;
    sampleValid = 1'b0;
    dataReady   = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_outputs", outs, 0);
    reset = 1'b1;
    @(negedge clock);
    check("idle_outputs", outs, 0);

    full_run(8'h10, 1'b0, -1, 1'b0, 1'b1);  // basic, full throughput
    full_run(8'h20, 1'b0,  4, 1'b0, 1'b0);  // consumer stall on slot 4
    full_run(8'h30, 1'b1, -1, 1'b0, 1'b0);  // source gaps
    full_run(8'h50, 1'b1, -1, 1'b1, 1'b0);  // start pulsed while busy

    // Strobe timeout on slot 2.
    suppress_slot = 4'd2;
    suppress_en   = 1'b1;
    done0         = done_cnt;
    pulse_start();
    fill(8'h40, 1'b0, 1'b0);
    drain(8'h40, -1, 1'b0, 2);
    n = 0;
    while (!error && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("timeout_cycles", n, Timeout);
    check("timeout_state", {error, busy, emptyBuffer, full, percent, dataValid},
          {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0});
    @(negedge clock);
    check("error_sticky", {error, busy}, 2'b10);
    check("timeout_no_done", done_cnt - done0, 0);
    suppress_en = 1'b0;
    full_run(8'h80, 1'b0, -1, 1'b0, 1'b0);  // start clears error

    // Asynchronous reset between edges, mid-drain.
    done0 = done_cnt;
    pulse_start();
    fill(8'h60, 1'b0, 1'b0);
    drain(8'h60, -1, 1'b0, 3);
    #2 reset = 1'b0;
    #1 check("reset_async", outs, 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_no_done", done_cnt - done0, 0);
    check("reset_idle", outs, 0);
    full_run(8'h70, 1'b0, -1, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed time-out, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
